// File: rtl/sram_arb_pkg.sv
// Shared types and the pixel-to-word address map for the framebuffer SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_DISP,
    ACC_WR,
    ACC_CLR
  } acc_t;

  typedef enum logic {
    CLR_IDLE,
    CLR_RUN
  } clr_state_t;

  // Each SRAM word holds two horizontal pixels, so x[0] does not select a word.
  function automatic logic [19:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
    return {2'b00, x[9:1], y[8:0]};
  endfunction

endpackage

// File: rtl/sram_wr_fifo.sv
// Small synchronous FIFO that queues paint writes as {addr, color} until the SRAM is free.
module sram_wr_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned Width      = 36
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [Width-1:0]            wdata,
  input  logic                        pop,
  output logic [Width-1:0]            rdata,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] DepthC = FIFO_DEPTH[PtrW:0];

  logic [Width-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             push_ok, pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Power-of-two depth lets the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok) begin
        count_q <= count_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == DepthC);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/sram_arbiter.sv
// Fixed-priority scheduler for the framebuffer SRAM: display reads, then queued paint
// writes, then full-screen clear writes; one registered access per cycle.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned X_MAX      = 640,
  parameter int unsigned Y_MAX      = 480,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        disp_req,
  input  logic [9:0]  disp_x,
  input  logic [9:0]  disp_y,
  output logic        disp_valid,
  output logic [15:0] disp_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [9:0]  wr_x,
  input  logic [9:0]  wr_y,
  input  logic [15:0] wr_color,
  input  logic        clr_start,
  input  logic [15:0] clr_color,
  output logic        clr_busy,
  output logic [19:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_out,
  output logic        SRAM_DQ_oe,
  input  logic [15:0] SRAM_DQ_in,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N
);

  localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [10:0] XLim   = 11'(X_MAX);
  localparam logic [10:0] YLim   = 11'(Y_MAX);
  localparam logic [8:0]  CxLast = 9'(X_MAX / 2 - 1);
  localparam logic [9:0]  CyLast = 10'(Y_MAX - 1);

  logic            disp_in_range, wr_in_range;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  logic [35:0]     fifo_rdata;
  acc_t            acc;
  logic            clr_adv;

  clr_state_t  clr_state_q, clr_state_d;
  logic [8:0]  cx_q, cx_d;
  logic [9:0]  cy_q, cy_d;
  logic [15:0] clr_color_q, clr_color_d;

  logic [19:0] addr_q, addr_d;
  logic [15:0] dq_out_q, dq_out_d;
  logic        dq_oe_q, dq_oe_d;
  logic        we_n_q, we_n_d;
  logic        oe_n_q, oe_n_d;
  logic        disp_p1_q, disp_oor_p1_q;
  logic        disp_valid_q;
  logic [15:0] disp_data_q, disp_data_d;

  assign disp_in_range = ({1'b0, disp_x} < XLim) && ({1'b0, disp_y} < YLim);
  assign wr_in_range   = ({1'b0, wr_x} < XLim) && ({1'b0, wr_y} < YLim);

  assign clr_busy  = (clr_state_q == CLR_RUN);
  assign wr_ready  = !fifo_full && !clr_busy && !reset;
  // Out-of-range writes still complete the handshake but are dropped here.
  assign fifo_push = wr_valid && wr_ready && wr_in_range;

  sram_wr_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .Width     (36)
  ) u_wr_fifo (
    .clk  (clk),
    .reset(reset),
    .push (fifo_push),
    .wdata({pix_addr(wr_x, wr_y), wr_color}),
    .pop  (fifo_pop),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  always_comb begin
    acc      = ACC_IDLE;
    fifo_pop = 1'b0;
    clr_adv  = 1'b0;
    if (disp_req && disp_in_range) begin
      acc = ACC_DISP;
    end else if (!fifo_empty) begin
      acc      = ACC_WR;
      fifo_pop = 1'b1;
    end else if (clr_busy) begin
      acc     = ACC_CLR;
      clr_adv = 1'b1;
    end
  end

  // Clear scan: cy is the inner loop, cx steps one SRAM word (two pixels) at a time.
  always_comb begin
    clr_state_d = clr_state_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    clr_color_d = clr_color_q;
    unique case (clr_state_q)
      CLR_IDLE: begin
        if (clr_start) begin
          clr_state_d = CLR_RUN;
          cx_d        = '0;
          cy_d        = '0;
          clr_color_d = clr_color;
        end
      end
      CLR_RUN: begin
        if (clr_adv) begin
          if (cy_q == CyLast) begin
            cy_d = '0;
            if (cx_q == CxLast) begin
              clr_state_d = CLR_IDLE;
            end else begin
              cx_d = cx_q + 1'b1;
            end
          end else begin
            cy_d = cy_q + 1'b1;
          end
        end
      end
      default: clr_state_d = CLR_IDLE;
    endcase
  end

  always_comb begin
    addr_d   = addr_q;
    dq_out_d = dq_out_q;
    dq_oe_d  = 1'b0;
    we_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    unique case (acc)
      ACC_DISP: begin
        addr_d = pix_addr(disp_x, disp_y);
        oe_n_d = 1'b0;
      end
      ACC_WR: begin
        addr_d   = fifo_rdata[35:16];
        dq_out_d = fifo_rdata[15:0];
        dq_oe_d  = 1'b1;
        we_n_d   = 1'b0;
      end
      ACC_CLR: begin
        addr_d   = pix_addr({cx_q, 1'b0}, cy_q);
        dq_out_d = clr_color_q;
        dq_oe_d  = 1'b1;
        we_n_d   = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    disp_data_d = disp_data_q;
    if (disp_p1_q) disp_data_d = disp_oor_p1_q ? 16'h0000 : SRAM_DQ_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_state_q   <= CLR_IDLE;
      cx_q          <= '0;
      cy_q          <= '0;
      clr_color_q   <= '0;
      addr_q        <= '0;
      dq_out_q      <= '0;
      dq_oe_q       <= 1'b0;
      we_n_q        <= 1'b1;
      oe_n_q        <= 1'b1;
      disp_p1_q     <= 1'b0;
      disp_oor_p1_q <= 1'b0;
      disp_valid_q  <= 1'b0;
      disp_data_q   <= '0;
    end else begin
      clr_state_q   <= clr_state_d;
      cx_q          <= cx_d;
      cy_q          <= cy_d;
      clr_color_q   <= clr_color_d;
      addr_q        <= addr_d;
      dq_out_q      <= dq_out_d;
      dq_oe_q       <= dq_oe_d;
      we_n_q        <= we_n_d;
      oe_n_q        <= oe_n_d;
      disp_p1_q     <= disp_req;
      disp_oor_p1_q <= !disp_in_range;
      disp_valid_q  <= disp_p1_q;
      disp_data_q   <= disp_data_d;
    end
  end

  assign SRAM_ADDR   = addr_q;
  assign SRAM_DQ_out = dq_out_q;
  assign SRAM_DQ_oe  = dq_oe_q;
  assign SRAM_WE_N   = we_n_q;
  assign SRAM_OE_N   = oe_n_q;
  assign disp_valid  = disp_valid_q;
  assign disp_data   = disp_data_q;

  fifo_count_bounded: assert property (@(posedge clk) disable iff (reset)
    fifo_count <= CntW'(FIFO_DEPTH));

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench: stimulus queues expected SRAM accesses and read responses; a negedge
// monitor pops and compares them as the arbiter presents strobes and disp_valid.
module tb_sram_arbiter;

  typedef struct {
    logic [19:0] addr;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        disp_req;
  logic [9:0]  disp_x, disp_y;
  logic        disp_valid;
  logic [15:0] disp_data;
  logic        wr_valid, wr_ready;
  logic [9:0]  wr_x, wr_y;
  logic [15:0] wr_color;
  logic        clr_start;
  logic [15:0] clr_color;
  logic        clr_busy;
  logic [19:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_out, SRAM_DQ_in;
  logic        SRAM_DQ_oe, SRAM_WE_N, SRAM_OE_N;

  logic [15:0] mem [0:65535];
  exp_t        wr_q[$], oe_q[$], rd_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          wr_seen = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_arbiter #(
    .X_MAX     (128),
    .Y_MAX     (64),
    .FIFO_DEPTH(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .disp_req   (disp_req),
    .disp_x     (disp_x),
    .disp_y     (disp_y),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_color   (wr_color),
    .clr_start  (clr_start),
    .clr_color  (clr_color),
    .clr_busy   (clr_busy),
    .SRAM_ADDR  (SRAM_ADDR),
    .SRAM_DQ_out(SRAM_DQ_out),
    .SRAM_DQ_oe (SRAM_DQ_oe),
    .SRAM_DQ_in (SRAM_DQ_in),
    .SRAM_WE_N  (SRAM_WE_N),
    .SRAM_OE_N  (SRAM_OE_N)
  );

  // Asynchronous SRAM model; the low 16 address bits cover every word this bench touches.
  assign SRAM_DQ_in = !SRAM_OE_N ? mem[SRAM_ADDR[15:0]] : 16'h0000;
  always @(posedge clk) begin
    if (!SRAM_WE_N && SRAM_DQ_oe) mem[SRAM_ADDR[15:0]] <= SRAM_DQ_out;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push_wr(input logic [19:0] a, input logic [15:0] d, input int c);
    exp_t e;
    e.addr = a; e.data = d; e.cyc = c;
    wr_q.push_back(e);
  endtask

  task automatic push_oe(input logic [19:0] a, input int c);
    exp_t e;
    e.addr = a; e.data = '0; e.cyc = c;
    oe_q.push_back(e);
  endtask

  task automatic push_rd(input logic [15:0] d, input int c);
    exp_t e;
    e.addr = '0; e.data = d; e.cyc = c;
    rd_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (!SRAM_WE_N) begin
        wr_seen++;
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_unexpected got addr %0h data %0h expected no strobe", SRAM_ADDR,
                   SRAM_DQ_out);
        end else begin
          e = wr_q.pop_front();
          chk("wr_access", {SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_OE_N},
              {e.addr, e.data, 1'b1, 1'b1});
          if (e.cyc >= 0) chk("wr_cycle", cyc, e.cyc);
        end
      end
      if (!SRAM_OE_N) begin
        if (oe_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL oe_unexpected got addr %0h expected no read", SRAM_ADDR);
        end else begin
          e = oe_q.pop_front();
          chk("rd_access", {SRAM_ADDR, SRAM_DQ_oe, SRAM_WE_N}, {e.addr, 1'b0, 1'b1});
          chk("rd_access_cycle", cyc, e.cyc);
        end
      end
      if (disp_valid) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL disp_unexpected got data %0h expected no disp_valid", disp_data);
        end else begin
          e = rd_q.pop_front();
          chk("disp_data", disp_data, e.data);
          chk("disp_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base, n;
    reset = 1'b1; disp_req = 1'b0; disp_x = '0; disp_y = '0;
    wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_color = '0;
    clr_start = 1'b0; clr_color = '0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sram", {SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_WE_N, SRAM_OE_N},
        {20'h0, 16'h0, 1'b0, 1'b1, 1'b1});
    chk("rst_disp", {disp_valid, disp_data}, {1'b0, 16'h0});
    chk("rst_busy_ready", {clr_busy, wr_ready}, 2'b00);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("wr_ready_after_reset", wr_ready, 1'b1);

    // Display read at (100,50)
    mem[16'h6432] = 16'hABCD;
    step();
    disp_req = 1'b1; disp_x = 10'd100; disp_y = 10'd50;
    push_oe(20'h06432, cyc + 1);
    push_rd(16'hABCD, cyc + 2);
    step();
    disp_req = 1'b0;
    repeat (4) step();

    // Paint write held off by 5 cycles of display reads
    mem[0] = 16'h1234;
    n = cyc;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        wr_valid = 1'b1; wr_x = 10'd10; wr_y = 10'd20; wr_color = 16'hF800;
        chk("paint_ready", wr_ready, 1'b1);
        push_wr(20'h00A14, 16'hF800, n + 6);
      end
      disp_req = 1'b1; disp_x = '0; disp_y = '0;
      push_oe(20'h0, cyc + 1);
      push_rd(16'h1234, cyc + 2);
      step();
      wr_valid = 1'b0;
    end
    disp_req = 1'b0;
    repeat (6) step();

    // FIFO fills to 4 under continuous display reads, then drains in push order
    n = cyc;
    for (int i = 0; i < 6; i++) begin
      disp_req = 1'b1; disp_x = '0; disp_y = '0;
      push_oe(20'h0, cyc + 1);
      push_rd(16'h1234, cyc + 2);
      if (i < 5) begin
        wr_valid = 1'b1;
        wr_x = 10'(2 * (i + 1)); wr_y = 10'(i + 1); wr_color = 16'(16'h1111 * (i + 1));
        chk("fifo_ready", wr_ready, (i < 4) ? 1'b1 : 1'b0);
      end else begin
        wr_valid = 1'b0;
      end
      step();
    end
    wr_valid = 1'b0; disp_req = 1'b0;
    push_wr(20'h00201, 16'h1111, n + 7);
    push_wr(20'h00402, 16'h2222, n + 8);
    push_wr(20'h00603, 16'h3333, n + 9);
    push_wr(20'h00804, 16'h4444, n + 10);
    repeat (12) step();
    chk("fifo_drained", wr_q.size(), 0);

    // Full clear with a second clr_start mid-run that must be ignored
    base = wr_seen;
    clr_start = 1'b1; clr_color = 16'hFFFF;
    for (int cx = 0; cx < 64; cx++) begin
      for (int cy = 0; cy < 64; cy++) begin
        push_wr(20'((cx << 9) | cy), 16'hFFFF, (cx == 0 && cy == 0) ? cyc + 2 : -1);
      end
    end
    step();
    clr_start = 1'b0; clr_color = '0;
    @(negedge clk);
    chk("clr_busy_set", clr_busy, 1'b1);
    for (int i = 0; i < 500 && (wr_seen - base) < 100; i++) step();
    clr_start = 1'b1; clr_color = 16'h0000;
    chk("clr_ready_low", wr_ready, 1'b0);
    step();
    clr_start = 1'b0;
    for (int i = 0; i < 10000 && clr_busy; i++) step();
    chk("clr_done", clr_busy, 1'b0);
    repeat (3) step();
    chk("clr_strobes", wr_seen - base, 4096);
    chk("clr_last_addr_held", SRAM_ADDR, 20'h07E3F);
    n = 0;
    for (int cx = 0; cx < 64; cx++) begin
      for (int cy = 0; cy < 64; cy++) begin
        if (mem[16'((cx << 9) | cy)] !== 16'hFFFF) n++;
      end
    end
    chk("clr_fill_bad_words", n, 0);

    // Reset at clear write #1000
    base = wr_seen;
    clr_start = 1'b1; clr_color = 16'h5A5A;
    for (int i = 0; i < 1000; i++) push_wr(20'(((i / 64) << 9) | (i % 64)), 16'h5A5A, -1);
    step();
    clr_start = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if (wr_seen - base >= 1000) break;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_clear_busy", clr_busy, 1'b0);
    repeat (20) step();
    chk("rst_mid_clear_strobes", wr_seen - base, 1000);
    chk("rst_mid_clear_queue", wr_q.size(), 0);

    // Out-of-range write completes the handshake but never strobes
    base = wr_seen;
    wr_valid = 1'b1; wr_x = 10'd700; wr_y = 10'd10; wr_color = 16'h07E0;
    chk("oor_wr_ready", wr_ready, 1'b1);
    step();
    wr_valid = 1'b0;
    repeat (5) step();
    chk("oor_wr_no_strobe", wr_seen - base, 0);

    // Display boundary: last row reads, row Y_MAX and column X_MAX return zero without OE
    mem[16'h003F] = 16'hBEEF;
    disp_req = 1'b1; disp_x = 10'd0; disp_y = 10'd63;
    push_oe(20'h0003F, cyc + 1);
    push_rd(16'hBEEF, cyc + 2);
    step();
    disp_x = 10'd0; disp_y = 10'd64;
    push_rd(16'h0000, cyc + 2);
    step();
    disp_x = 10'd128; disp_y = 10'd0;
    push_rd(16'h0000, cyc + 2);
    step();
    disp_req = 1'b0;
    repeat (6) step();

    chk("queues_empty", {wr_q.size(), oe_q.size(), rd_q.size()}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
